// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data memory stage: word RAM plus LED/switch/counter/timer I/O block
module dmem_mmio #(
    parameter int RAM_WORDS = 64,
    parameter int SW_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [31:0]         wd,
    output logic [31:0]         rd,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [SW_WIDTH-1:0] led,
    output logic                irq
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]         r_ram [RAM_WORDS];
    logic [SW_WIDTH-1:0] r_led;
    logic [SW_WIDTH-1:0] r_sw_meta;
    logic [SW_WIDTH-1:0] r_sw_sync;
    logic [31:0]         r_count;
    logic [31:0]         r_cmp;
    logic                r_expired;

    logic          w_io_sel;
    logic [5:0]    w_off;
    logic [AW-1:0] w_idx;
    logic          w_wr_ram;
    logic          w_wr_led;
    logic          w_wr_count;
    logic          w_wr_cmp;
    logic          w_wr_clr;
    logic          w_hit;
    logic          w_unused;

    assign w_io_sel   = (addr[31:16] == 16'hFFFF);
    assign w_off      = addr[7:2];
    assign w_idx      = addr[AW+1:2];
    assign w_wr_ram   = we & ~w_io_sel;
    assign w_wr_led   = we & w_io_sel & (w_off == 6'h00);
    assign w_wr_count = we & w_io_sel & (w_off == 6'h02);
    assign w_wr_cmp   = we & w_io_sel & (w_off == 6'h03);
    assign w_wr_clr   = we & w_io_sel & (w_off == 6'h04) & wd[0];
    // A zero compare value parks the timer.
    assign w_hit      = (r_cmp != 32'd0) && (r_count == r_cmp);
    assign w_unused   = ^addr;

    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_idx] <= wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_count   <= 32'd0;
            r_cmp     <= 32'd0;
            r_expired <= 1'b0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            r_count   <= w_wr_count ? 32'd0 : r_count + 32'd1;
            if (w_wr_led) begin
                r_led <= wd[SW_WIDTH-1:0];
            end
            if (w_wr_cmp) begin
                r_cmp <= wd;
            end
            // Setting outranks a simultaneous clear so an expiry is never lost.
            if (w_hit) begin
                r_expired <= 1'b1;
            end else if (w_wr_clr) begin
                r_expired <= 1'b0;
            end
        end
    end

    always_comb begin
        rd = 32'd0;
        if (w_io_sel) begin
            case (w_off)
                6'h00:   rd = {{(32-SW_WIDTH){1'b0}}, r_led};
                6'h01:   rd = {{(32-SW_WIDTH){1'b0}}, r_sw_sync};
                6'h02:   rd = r_count;
                6'h03:   rd = r_cmp;
                6'h04:   rd = {31'd0, r_expired};
                default: rd = 32'd0;
            endcase
        end else begin
            rd = r_ram[w_idx];
        end
    end

    assign led = r_led;
    assign irq = r_expired;
endmodule
